// File: rtl/pixel_writer_pkg.sv
// Shared types for the pixel writer: screen defaults, the queued write payload
// and the write FSM state.
package pixel_writer_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int PW_ADDR_W    = 19;
  localparam int PW_COLOR_W   = 16;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } point2d_t;

  typedef struct packed {
    logic [PW_ADDR_W-1:0]  addr;
    logic [PW_COLOR_W-1:0] color;
  } pixel_write_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } writer_state_t;

endpackage

// File: rtl/pixel_writer_fifo.sv
// Synchronous FIFO of pending framebuffer writes; the extra pointer bit
// distinguishes full from empty when the indices match.
module pixel_writer_fifo
  import pixel_writer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic         pop,
  input  pixel_write_t din,
  output pixel_write_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  pixel_write_t mem [DEPTH];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pixel_writer.sv
// Clips rasterizer points to the screen, queues them, and writes them to the
// framebuffer over a req/ack handshake; reports line drain and overflow.
//
// state | meaning
// IDLE  | no write outstanding; pops the FIFO head as soon as one is queued
// WRITE | mem_wen high, addr/data held until mem_ack, then next entry or IDLE
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = PW_ADDR_W,
  parameter int COLOR_W    = PW_COLOR_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  point2d_t           point,
  input  logic               plot,
  input  logic [COLOR_W-1:0] color,
  input  logic               line_done,
  output logic               stall,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_wen,
  input  logic               mem_ack,
  output logic               drained,
  output logic               overflow,
  output logic [15:0]        clip_count
);

  localparam logic signed [15:0] W_S = 16'(SCREEN_W);
  localparam logic signed [15:0] H_S = 16'(SCREEN_H);

  writer_state_t state, state_nxt;
  logic signed [15:0] px, py;
  logic               in_range;
  logic [ADDR_W-1:0]  addr_calc;
  logic               push, pop, full, empty, pending;
  pixel_write_t       push_data, pop_data;

  assign px        = point.x;
  assign py        = point.y;
  assign in_range  = (px >= 16'sd0) && (px < W_S) && (py >= 16'sd0) && (py < H_S);
  assign addr_calc = ADDR_W'(({16'd0, py} * 32'(SCREEN_W)) + {16'd0, px});

  assign push_data.addr  = PW_ADDR_W'(addr_calc);
  assign push_data.color = PW_COLOR_W'(color);
  assign push            = plot && in_range && (!full || pop);
  assign stall           = full;

  pixel_writer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (pop_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          if (!empty) pop       = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_wen = (state == WRITE);
  // A push blocks the pulse so a pixel arriving with line_done is covered.
  assign drained = pending && empty && (state == IDLE) && !push;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pending    <= 1'b0;
      overflow   <= 1'b0;
      clip_count <= '0;
    end else begin
      if (pop) begin
        mem_addr  <= ADDR_W'(pop_data.addr);
        mem_wdata <= COLOR_W'(pop_data.color);
      end
      if (drained)        pending <= 1'b0;
      else if (line_done) pending <= 1'b1;
      if (plot && in_range && full && !pop) overflow <= 1'b1;
      if (plot && !in_range && (clip_count != 16'hFFFF))
        clip_count <= clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: latency, clipping, overflow, random ack
// stability and mid-write reset.
module tb_pixel_writer;
  import pixel_writer_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  point2d_t    point;
  logic        plot, line_done, mem_ack;
  logic [15:0] color;
  logic        stall, mem_wen, drained, overflow;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] clip_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int drain_cnt = 0;
  int stab_err = 0;
  logic        hold_prev = 1'b0;
  logic [34:0] held;
  logic [34:0] wq[$];
  int          wc[$];
  logic        st[10];

  always #5 clk = ~clk;

  pixel_writer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .point      (point),
    .plot       (plot),
    .color      (color),
    .line_done  (line_done),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ack    (mem_ack),
    .drained    (drained),
    .overflow   (overflow),
    .clip_count (clip_count)
  );

  always @(negedge clk) begin
    cyc++;
    if (!n_rst) begin
      hold_prev = 1'b0;
    end else begin
      if (mem_wen && mem_ack) begin
        wq.push_back({mem_addr, mem_wdata});
        wc.push_back(cyc);
      end
      if (hold_prev && mem_wen && ({mem_addr, mem_wdata} != held)) stab_err++;
      hold_prev = mem_wen && !mem_ack;
      held = {mem_addr, mem_wdata};
      if (drained) drain_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_pt(input int x, input int y, input logic [15:0] c, input logic ld);
    point.x   = 16'(x);
    point.y   = 16'(y);
    color     = c;
    plot      = 1'b1;
    line_done = ld;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    n_rst = 1'b0;
    plot = 1'b0;
    line_done = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    wq.delete();
    wc.delete();
    drain_cnt = 0;
    stab_err = 0;
  endtask

  initial begin
    int i;
    int cycles;
    plot = 1'b0; line_done = 1'b0; mem_ack = 1'b0; point = '0; color = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_clip", 32'(clip_count), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    n_rst = 1'b1;

    // single plot with line_done, ack held high
    mem_ack = 1'b1;
    step();
    drive_pt(10, 2, 16'h1234, 1'b1);
    step();
    plot = 1'b0; line_done = 1'b0;
    @(negedge clk);
    chk("t1_wen_c1", 32'(mem_wen), 32'd0);
    chk("t1_drn_c1", 32'(drained), 32'd0);
    @(negedge clk);
    chk("t1_wen_c2", 32'(mem_wen), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd1290);
    chk("t1_wdata", 32'(mem_wdata), 32'h1234);
    chk("t1_drn_c2", 32'(drained), 32'd0);
    @(negedge clk);
    chk("t1_wen_c3", 32'(mem_wen), 32'd0);
    chk("t1_drn_c3", 32'(drained), 32'd1);
    @(negedge clk);
    chk("t1_drn_c4", 32'(drained), 32'd0);
    repeat (4) @(negedge clk);
    chk("t1_drn_cnt", 32'(drain_cnt), 32'd1);
    chk("t1_writes", 32'(wq.size()), 32'd1);

    // clipping and saturation
    reset_dut();
    step(); drive_pt(-1, 0, 16'h1, 1'b0);
    step(); drive_pt(640, 5, 16'h2, 1'b0);
    step(); drive_pt(3, 480, 16'h3, 1'b0);
    step(); plot = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_clip3", 32'(clip_count), 32'd3);
    chk("t2_wen", 32'(mem_wen), 32'd0);
    chk("t2_writes", 32'(wq.size()), 32'd0);
    step(); drive_pt(-1, -1, 16'h4, 1'b0);
    repeat (65540) step();
    plot = 1'b0;
    @(negedge clk);
    chk("t2_clip_sat", 32'(clip_count), 32'hFFFF);
    chk("t2_sat_writes", 32'(wq.size()), 32'd0);

    // overflow with ack held low: one entry sits in the write register, 8 queue
    reset_dut();
    mem_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      drive_pt(k, 0, 16'(32'h100 + k), 1'b0);
      @(negedge clk);
      st[k] = stall;
    end
    step(); plot = 1'b0;
    @(negedge clk);
    chk("t3_stall_p8", 32'(st[8]), 32'd0);
    chk("t3_stall_p9", 32'(st[9]), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_no_write", 32'(wq.size()), 32'd0);
    step(); mem_ack = 1'b1;
    repeat (15) @(negedge clk);
    chk("t3_writes", 32'(wq.size()), 32'd9);
    for (int k = 0; k < 9 && k < wq.size(); k++) begin
      chk($sformatf("t3_addr%0d", k), 32'(wq[k][34:16]), 32'(k));
      chk($sformatf("t3_data%0d", k), 32'(wq[k][15:0]), 32'h100 + 32'(k));
    end
    if (wc.size() >= 9) chk("t3_b2b", 32'(wc[8] - wc[0]), 32'd8);
    else chk("t3_b2b_cnt", 32'(wc.size()), 32'd9);

    // random ack over a 20-pixel line, repeated line_done
    reset_dut();
    i = 0; cycles = 0;
    while (i < 20 && cycles < 500) begin
      step(); cycles++;
      mem_ack = 1'($urandom_range(0, 1));
      if (!stall) begin
        drive_pt(i, 1, 16'(i * 3), i >= 17);
        i++;
      end else begin
        plot = 1'b0; line_done = 1'b0;
      end
    end
    step(); plot = 1'b0; line_done = 1'b0;
    cycles = 0;
    while (wq.size() < 20 && cycles < 500) begin
      mem_ack = 1'($urandom_range(0, 1));
      step(); cycles++;
    end
    mem_ack = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("t4_sent", 32'(i), 32'd20);
    chk("t4_writes", 32'(wq.size()), 32'd20);
    for (int k = 0; k < 20 && k < wq.size(); k++) begin
      chk($sformatf("t4_addr%0d", k), 32'(wq[k][34:16]), 32'd640 + 32'(k));
      chk($sformatf("t4_data%0d", k), 32'(wq[k][15:0]), 32'(k * 3));
    end
    chk("t4_stable", 32'(stab_err), 32'd0);
    chk("t4_drn_cnt", 32'(drain_cnt), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);

    // reset mid-write with 4 entries queued
    reset_dut();
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      drive_pt(100 + k, 7, 16'(32'hA0 + k), k == 4);
    end
    step(); plot = 1'b0; line_done = 1'b0;
    @(negedge clk);
    chk("t5_wen_pre", 32'(mem_wen), 32'd1);
    #1 n_rst = 1'b0;
    #1;
    chk("t5_wen_rst", 32'(mem_wen), 32'd0);
    chk("t5_addr_rst", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    mem_ack = 1'b1;
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_writes", 32'(wq.size()), 32'd0);
    chk("t5_drn_cnt", 32'(drain_cnt), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_clip", 32'(clip_count), 32'd0);
    chk("t5_wen", 32'(mem_wen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
